// File: rtl/addsub.sv
// ---------------------------------------------------------------------------
// addsub
//   Two's-complement adder/subtractor with a registered result and ALU
//   status flags. This is the arithmetic core of the datapath ALU. One
//   control bit selects A+B or A-B. The result and flags appear one clock
//   after the operands are sampled.
//
// Parameters
//   WIDTH : operand and result width in bits (must be >= 2)
//
// Ports
//   clk : rising-edge clock
//   rst : synchronous, active-high reset
//   a   : operand A
//   b   : operand B
//   sub : 0 = A+B, 1 = A-B
//   sum : registered result, modulo 2^WIDTH
//   cf  : carry-out on add, borrow on subtract
//   ovf : signed (two's-complement) overflow
//   sf  : sign flag, copy of sum[WIDTH-1]
//   zf  : zero flag, set when a computed sum is all zeros
// ---------------------------------------------------------------------------
module addsub #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic [WIDTH-1:0] sum,
  output logic             cf,
  output logic             ovf,
  output logic             sf,
  output logic             zf
);

  logic [WIDTH-1:0] bx;
  logic [WIDTH:0]   raw;
  logic             carryIntoMsb;

  logic [WIDTH-1:0] sumD, sumQ;
  logic             cfD, cfQ;
  logic             ovfD, ovfQ;
  logic             sfD, sfQ;
  logic             zfD, zfQ;

  // Subtraction is A + ~B + 1: B is inverted by sub and sub is the carry-in,
  // so one adder serves both operations.
  always_comb begin
    bx  = b ^ {WIDTH{sub}};
    raw = {1'b0, a} + {1'b0, bx} + {{WIDTH{1'b0}}, sub};

    // The carry into the MSB is recovered from the MSB sum bit: the sum bit
    // is the XOR of both operand bits and the incoming carry.
    carryIntoMsb = a[WIDTH-1] ^ bx[WIDTH-1] ^ raw[WIDTH-1];

    sumD = raw[WIDTH-1:0];
    // The adder carry-out is inverted on subtract so that cf reads as an
    // unsigned borrow (set exactly when a < b).
    cfD  = raw[WIDTH] ^ sub;
    ovfD = carryIntoMsb ^ raw[WIDTH];
    sfD  = raw[WIDTH-1];
    zfD  = (raw[WIDTH-1:0] == '0);
  end

  // Output registers. Reset clears every flag, including zf, because zf only
  // describes computed results and the reset state is not one.
  always_ff @(posedge clk) begin
    if (rst) begin
      sumQ <= '0;
      cfQ  <= 1'b0;
      ovfQ <= 1'b0;
      sfQ  <= 1'b0;
      zfQ  <= 1'b0;
    end else begin
      sumQ <= sumD;
      cfQ  <= cfD;
      ovfQ <= ovfD;
      sfQ  <= sfD;
      zfQ  <= zfD;
    end
  end

  assign sum = sumQ;
  assign cf  = cfQ;
  assign ovf = ovfQ;
  assign sf  = sfQ;
  assign zf  = zfQ;

endmodule

// File: tb/tb_addsub.sv
// ---------------------------------------------------------------------------
// tb_addsub
//   Directed bench for addsub at WIDTH=32. Operands are driven on the
//   falling edge, and outputs are checked 1 time unit after the next rising
//   edge. Every check is an immediate assertion against a hand-computed or
//   independently modelled value.
// ---------------------------------------------------------------------------
module tb_addsub;

  logic        clk;
  logic        rst;
  logic [31:0] a;
  logic [31:0] b;
  logic        sub;
  logic [31:0] sum;
  logic        cf;
  logic        ovf;
  logic        sf;
  logic        zf;

  int errors;
  int checks;

  addsub #(.WIDTH(32)) dut (
    .clk (clk),
    .rst (rst),
    .a   (a),
    .b   (b),
    .sub (sub),
    .sum (sum),
    .cf  (cf),
    .ovf (ovf),
    .sf  (sf),
    .zf  (zf)
  );

  // Free-running clock, period 10.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Drive one operation on the falling edge, then advance to just after the
  // rising edge that captures it.
  task automatic applyStimulus(input logic r, input logic [31:0] av,
                               input logic [31:0] bv, input logic s);
    @(negedge clk);
    rst = r;
    a   = av;
    b   = bv;
    sub = s;
    @(posedge clk);
    #1;
  endtask

  // Compare every output against the expected values.
  task automatic checkOutput(input string tag, input logic [31:0] eSum,
                             input logic eCf, input logic eOvf,
                             input logic eSf, input logic eZf);
    checks++;
    assert (sum === eSum) else begin
      errors++;
      $error("[TB] FAIL %s sum observed=%h expected=%h", tag, sum, eSum);
    end
    checks++;
    assert (cf === eCf) else begin
      errors++;
      $error("[TB] FAIL %s cf observed=%b expected=%b", tag, cf, eCf);
    end
    checks++;
    assert (ovf === eOvf) else begin
      errors++;
      $error("[TB] FAIL %s ovf observed=%b expected=%b", tag, ovf, eOvf);
    end
    checks++;
    assert (sf === eSf) else begin
      errors++;
      $error("[TB] FAIL %s sf observed=%b expected=%b", tag, sf, eSf);
    end
    checks++;
    assert (zf === eZf) else begin
      errors++;
      $error("[TB] FAIL %s zf observed=%b expected=%b", tag, zf, eZf);
    end
  endtask

  // Reference model built from unsigned comparison and sign rules rather
  // than from carry bits.
  task automatic modelOp(input logic [31:0] av, input logic [31:0] bv,
                         input logic s, output logic [31:0] eSum,
                         output logic eCf, output logic eOvf,
                         output logic eSf, output logic eZf);
    longint unsigned wide;
    if (s) begin
      eSum = av - bv;
      eCf  = (av < bv);
      eOvf = (av[31] != bv[31]) && (eSum[31] != av[31]);
    end else begin
      wide = longint'(av) + longint'(bv);
      eSum = av + bv;
      eCf  = (wide > 64'h0000_0000_FFFF_FFFF);
      eOvf = (av[31] == bv[31]) && (eSum[31] != av[31]);
    end
    eSf = eSum[31];
    eZf = (eSum == 32'h0);
  endtask

  initial begin
    logic [31:0] ra;
    logic [31:0] rb;
    logic        rs;
    logic [31:0] eSum;
    logic        eCf;
    logic        eOvf;
    logic        eSf;
    logic        eZf;
    logic [31:0] heldSum;

    errors = 0;
    checks = 0;
    rst = 1'b1;
    a   = 32'h0;
    b   = 32'h0;
    sub = 1'b0;

    // Reset state: everything zero, zf included.
    applyStimulus(1'b1, 32'd0, 32'd0, 1'b0);
    checkOutput("reset", 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);

    // Basic add and subtract, back to back.
    applyStimulus(1'b0, 32'd16, 32'd12, 1'b0);
    checkOutput("add16+12", 32'd28, 1'b0, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 32'd16, 32'd12, 1'b1);
    checkOutput("sub16-12", 32'd4, 1'b0, 1'b0, 1'b0, 1'b0);

    // Carries across byte boundaries.
    applyStimulus(1'b0, 32'h7F, 32'd2, 1'b0);
    checkOutput("add7F+2", 32'h81, 1'b0, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 32'hFF, 32'd2, 1'b0);
    checkOutput("addFF+2", 32'h101, 1'b0, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 32'hFFFF, 32'd1, 1'b0);
    checkOutput("addFFFF+1", 32'h10000, 1'b0, 1'b0, 1'b0, 1'b0);

    // Signed overflow on add.
    applyStimulus(1'b0, 32'h7FFF_FFFF, 32'd2, 1'b0);
    checkOutput("addOvf", 32'h8000_0001, 1'b0, 1'b1, 1'b1, 1'b0);

    // Outputs must not follow input changes between edges.
    heldSum = 32'h8000_0001;
    a = 32'h1234_5678;
    b = 32'h1111_1111;
    sub = 1'b1;
    #2;
    checks++;
    assert (sum === heldSum) else begin
      errors++;
      $error("[TB] FAIL holdBetweenEdges sum observed=%h expected=%h", sum, heldSum);
    end

    // Borrow on subtract.
    applyStimulus(1'b0, 32'h16, 32'h17, 1'b1);
    checkOutput("subBorrow", 32'hFFFF_FFFF, 1'b1, 1'b0, 1'b1, 1'b0);

    // Wrap to zero.
    applyStimulus(1'b0, 32'hFFFF_FFFF, 32'd1, 1'b0);
    checkOutput("wrapZero", 32'h0, 1'b1, 1'b0, 1'b0, 1'b1);

    // a == b under subtract.
    applyStimulus(1'b0, 32'h1234_5678, 32'h1234_5678, 1'b1);
    checkOutput("subEqual", 32'h0, 1'b0, 1'b0, 1'b0, 1'b1);

    // Signed overflow on subtract.
    applyStimulus(1'b0, 32'h8000_0000, 32'd1, 1'b1);
    checkOutput("subOvf", 32'h7FFF_FFFF, 1'b0, 1'b1, 1'b0, 1'b0);

    // Negative minus positive without overflow.
    applyStimulus(1'b0, 32'hFFFF_FFFE, 32'd3, 1'b1);
    checkOutput("subNegPos", 32'hFFFF_FFFB, 1'b0, 1'b0, 1'b1, 1'b0);

    // Reset wins over operands; release produces the held operation.
    applyStimulus(1'b1, 32'd5, 32'd3, 1'b0);
    checkOutput("resetMid", 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 32'd5, 32'd3, 1'b0);
    checkOutput("afterReset", 32'd8, 1'b0, 1'b0, 1'b0, 1'b0);

    // Random operations against the reference model.
    for (int i = 0; i < 16; i++) begin
      ra = $urandom;
      rb = (i % 4 == 3) ? ra : $urandom;
      rs = 1'($urandom_range(0, 1));
      modelOp(ra, rb, rs, eSum, eCf, eOvf, eSf, eZf);
      applyStimulus(1'b0, ra, rb, rs);
      checkOutput($sformatf("rand%0d", i), eSum, eCf, eOvf, eSf, eZf);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
